// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline buffers.
// Control bundle layout, occupancy states and per-boundary data widths.
package pipe_pkg;

   localparam int DEFAULT_CTRL_W = 9;

   localparam int CTRL_REG_WRITE   = 0;
   localparam int CTRL_ALU_SRC     = 1;
   localparam int CTRL_MEM_TO_WRITE = 2;
   localparam int CTRL_ALU_OP_LO   = 3;
   localparam int CTRL_ALU_OP_HI   = 4;
   localparam int CTRL_MEM_TO_REG  = 5;
   localparam int CTRL_MEM_TO_READ = 6;
   localparam int CTRL_BRANCH      = 7;
   localparam int CTRL_REG_DST     = 8;

   localparam int FD_DATA_W = 64;
   localparam int DE_DATA_W = 149;
   localparam int EM_DATA_W = 101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } occState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Used for bubble telemetry on the pipeline buffers.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, flush,
// optional skid entry and bubble/occupancy telemetry.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEFAULT_CTRL_W,
   parameter int DATA_W = 128,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              flush_i,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  bubbles_o
);

   occState_e stQ;
   occState_e stD;

   logic [CTRL_W-1:0] mainCtrl;
   logic [CTRL_W-1:0] skidCtrl;
   logic [DATA_W-1:0] mainData;
   logic [DATA_W-1:0] skidData;
   logic              readyQ;
   logic              validQ;
   logic              readyOut;
   logic              inXfer;
   logic              outXfer;

   assign validQ   = (stQ != ST_EMPTY);
   // Skid variant never looks at ready_i when producing ready_o.
   assign readyOut = (SKID != 0) ? readyQ : (ready_i | ~validQ);
   assign inXfer   = valid_i & readyOut;
   assign outXfer  = validQ & ready_i;

   always_comb begin
      stD = stQ;
      if (flush_i) begin
         stD = ST_EMPTY;
      end else begin
         unique case (stQ)
            ST_EMPTY: begin
               if (inXfer) stD = ST_FULL;
            end
            ST_FULL: begin
               if (inXfer && !outXfer) begin
                  stD = (SKID != 0) ? ST_SKID : ST_FULL;
               end else if (outXfer && !inXfer) begin
                  stD = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (outXfer) stD = ST_FULL;
            end
            default: stD = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stQ      <= ST_EMPTY;
         readyQ   <= 1'b1;
         mainCtrl <= '0;
         mainData <= '0;
         skidCtrl <= '0;
         skidData <= '0;
      end else begin
         stQ    <= stD;
         readyQ <= (stD != ST_SKID);
         if (!flush_i) begin
            if (inXfer) begin
               if (stD == ST_SKID) begin
                  skidCtrl <= ctrl_i;
                  skidData <= data_i;
               end else begin
                  mainCtrl <= ctrl_i;
                  mainData <= data_i;
               end
            end else if ((stQ == ST_SKID) && outXfer) begin
               mainCtrl <= skidCtrl;
               mainData <= skidData;
            end
         end
      end
   end

   assign ready_o     = readyOut;
   assign valid_o     = validQ;
   assign ctrl_o      = validQ ? mainCtrl : '0;
   assign data_o      = mainData;
   assign occupancy_o = stQ;

   sat_counter #(
      .CNT_W(CNT_W)
   ) uBubbles (
      .clk  (clk_i),
      .rstN (rst_ni),
      .inc  (ready_i & ~validQ),
      .count(bubbles_o)
   );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench: skid and non-skid buffers against a queue model.
// Inputs driven on negedge, outputs sampled 1ns later.
module tb_pipe_stage_buffer;

   localparam int CW = 9;
   localparam int DW = 128;
   localparam int NW = 4;

   typedef logic [CW+DW-1:0] beat_t;
   typedef logic [1+2+1+CW+NW+DW-1:0] obs_t;

   logic clk = 1'b0;
   logic rstN;

   logic          vA, rA, fA, rdyA, voA;
   logic [CW-1:0] cA, coA;
   logic [DW-1:0] dA, doA;
   logic [1:0]    occA;
   logic [NW-1:0] bubA;

   logic          vB, rB, fB, rdyB, voB;
   logic [CW-1:0] cB, coB;
   logic [DW-1:0] dB, doB;
   logic [1:0]    occB;
   logic [NW-1:0] bubB;

   beat_t qA[$];
   beat_t qB[$];
   beat_t lastA, lastB;
   int    cntA, cntB;
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   pipe_stage_buffer #(
      .CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)
   ) dutA (
      .clk_i(clk), .rst_ni(rstN),
      .valid_i(vA), .ready_o(rdyA), .ctrl_i(cA), .data_i(dA),
      .valid_o(voA), .ready_i(rA), .ctrl_o(coA), .data_o(doA),
      .flush_i(fA), .occupancy_o(occA), .bubbles_o(bubA)
   );

   pipe_stage_buffer #(
      .CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)
   ) dutB (
      .clk_i(clk), .rst_ni(rstN),
      .valid_i(vB), .ready_o(rdyB), .ctrl_i(cB), .data_i(dB),
      .valid_o(voB), .ready_i(rB), .ctrl_o(coB), .data_o(doB),
      .flush_i(fB), .occupancy_o(occB), .bubbles_o(bubB)
   );

   function automatic beat_t rndBeat();
      beat_t b;
      b = {CW'($urandom), $urandom, $urandom, $urandom, $urandom};
      return b;
   endfunction

   // Model view: the buffer is a FIFO of capacity 2 (skid) or 1.
   function automatic obs_t expA();
      int    n;
      beat_t f;
      n = qA.size();
      f = (n > 0) ? qA[0] : '0;
      return {(n > 0) ? 1'b1 : 1'b0, 2'(n), (n < 2) ? 1'b1 : 1'b0,
              (n > 0) ? f[CW+DW-1:DW] : {CW{1'b0}}, NW'(cntA),
              lastA[DW-1:0]};
   endfunction

   function automatic obs_t expB();
      int    n;
      beat_t f;
      n = qB.size();
      f = (n > 0) ? qB[0] : '0;
      return {(n > 0) ? 1'b1 : 1'b0, 2'(n), (rB || n == 0) ? 1'b1 : 1'b0,
              (n > 0) ? f[CW+DW-1:DW] : {CW{1'b0}}, NW'(cntB),
              lastB[DW-1:0]};
   endfunction

   function automatic obs_t obsA();
      return {voA, occA, rdyA, coA, bubA, doA};
   endfunction

   function automatic obs_t obsB();
      return {voB, occB, rdyB, coB, bubB, doB};
   endfunction

   task automatic resetModels();
      qA.delete();
      qB.delete();
      lastA = '0;
      lastB = '0;
      cntA = 0;
      cntB = 0;
   endtask

   task automatic idleInputs();
      vA = 0; rA = 0; fA = 0; cA = '0; dA = '0;
      vB = 0; rB = 0; fB = 0; cB = '0; dB = '0;
   endtask

   task automatic doReset();
      idleInputs();
      rstN = 1'b0;
      resetModels();
      @(negedge clk);
      rstN = 1'b1;
   endtask

   // Advance one clock and update both models from the applied inputs.
   task automatic tick();
      int szA, szB;
      logic accA, accB;
      szA = qA.size();
      szB = qB.size();
      accA = vA && (szA < 2);
      accB = vB && (rB || szB == 0);
      @(posedge clk);
      if (rA && szA == 0 && cntA < 15) cntA++;
      if (rB && szB == 0 && cntB < 15) cntB++;
      if (fA) begin
         qA.delete();
      end else begin
         if (szA > 0 && rA) void'(qA.pop_front());
         if (accA) qA.push_back({cA, dA});
      end
      if (fB) begin
         qB.delete();
      end else begin
         if (szB > 0 && rB) void'(qB.pop_front());
         if (accB) qB.push_back({cB, dB});
      end
      if (qA.size() > 0) lastA = qA[0];
      if (qB.size() > 0) lastB = qB[0];
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t rstVal;
      beat_t b;
      rstVal = {1'b0, 2'd0, 1'b1, {CW{1'b0}}, {NW{1'b0}}, {DW{1'b0}}};
      rA = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL reset_idle c%0d got=%h exp=%h", i, obsA(), expA());
         end
         total++;
         tick();
      end
      rA = 0;
      for (int i = 0; i < 3; i++) begin
         b = rndBeat();
         vA = (i < 2);
         {cA, dA} = b;
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL reset_fill c%0d got=%h exp=%h", i, obsA(), expA());
         end
         total++;
         tick();
      end
      idleInputs();
      rstN = 1'b0;
      #1;
      if (obsA() !== rstVal) begin
         bad++;
         $display("FAIL reset_async_a got=%h exp=%h", obsA(), rstVal);
      end
      total++;
      if (obsB() !== rstVal) begin
         bad++;
         $display("FAIL reset_async_b got=%h exp=%h", obsB(), rstVal);
      end
      total++;
      resetModels();
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic test_stream();
      logic [DW-1:0] outs[$];
      int err;
      rA = 1;
      for (int i = 0; i < 12; i++) begin
         vA = (i < 8);
         dA = DW'(i + 1);
         cA = CW'($urandom);
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL stream c%0d got=%h exp=%h", i, obsA(), expA());
         end
         total++;
         if (voA && rA) outs.push_back(doA);
         tick();
      end
      vA = 0;
      err = (outs.size() != 8) ? 1 : 0;
      for (int k = 0; k < outs.size(); k++)
         if (outs[k] !== DW'(k + 1)) err = 1;
      if (err != 0) begin
         bad++;
         $display("FAIL stream_order got_n=%0d exp_n=8", outs.size());
      end
      total++;
   endtask

   task automatic test_stall_fill();
      logic [DW-1:0] outs[$];
      logic [DW-1:0] seq[3];
      int sent, cyc;
      seq[0] = DW'(32'hA);
      seq[1] = DW'(32'hB);
      seq[2] = DW'(32'hC);
      rA = 0;
      sent = 0;
      cyc = 0;
      while (cyc < 20) begin
         if (cyc == 5) rA = 1;
         vA = (sent < 3);
         dA = seq[(sent < 3) ? sent : 2];
         cA = CW'(sent + 1);
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL stall c%0d got=%h exp=%h", cyc, obsA(), expA());
         end
         total++;
         if (voA && rA) outs.push_back(doA);
         if (vA && qA.size() < 2) sent++;
         tick();
         cyc++;
      end
      vA = 0;
      if (sent != 3) begin
         bad++;
         $display("FAIL stall_accept got=%0d exp=3", sent);
      end
      total++;
      if (outs.size() != 3) begin
         bad++;
         $display("FAIL stall_count got=%0d exp=3", outs.size());
      end else if (outs[0] !== seq[0] || outs[1] !== seq[1]
                   || outs[2] !== seq[2]) begin
         bad++;
         $display("FAIL stall_order got=%h,%h,%h exp=a,b,c",
                  outs[0], outs[1], outs[2]);
      end
      total++;
   endtask

   task automatic test_flush();
      int seenD;
      seenD = 0;
      for (int pass = 0; pass < 2; pass++) begin
         rA = 0;
         for (int i = 0; i < 2 - pass; i++) begin
            vA = 1;
            {cA, dA} = rndBeat();
            dA[DW-1] = 1'b1;
            #1;
            if (obsA() !== expA()) begin
               bad++;
               $display("FAIL flush_fill p%0d got=%h exp=%h",
                        pass, obsA(), expA());
            end
            total++;
            tick();
         end
         vA = 1;
         fA = 1;
         dA = DW'(32'hD);
         cA = {CW{1'b1}};
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL flush_pre p%0d got=%h exp=%h",
                     pass, obsA(), expA());
         end
         total++;
         tick();
         vA = 0;
         fA = 0;
         rA = 1;
         for (int i = 0; i < 3; i++) begin
            #1;
            if (obsA() !== expA()) begin
               bad++;
               $display("FAIL flush_post p%0d c%0d got=%h exp=%h",
                        pass, i, obsA(), expA());
            end
            total++;
            if (voA && doA === DW'(32'hD)) seenD++;
            tick();
         end
      end
      if (seenD != 0) begin
         bad++;
         $display("FAIL flush_drop got=%0d exp=0", seenD);
      end
      total++;
   endtask

   task automatic test_skid0();
      logic [DW-1:0] outs[$];
      int nb, err;
      nb = 1;
      cB = CW'($urandom);
      for (int i = 0; i < 20; i++) begin
         vB = (i < 16);
         rB = (i >= 16) || (i % 2 == 0);
         dB = DW'(nb);
         #1;
         if (obsB() !== expB()) begin
            bad++;
            $display("FAIL skid0 c%0d got=%h exp=%h", i, obsB(), expB());
         end
         total++;
         if (voB && rB) outs.push_back(doB);
         if (vB && (rB || qB.size() == 0)) begin
            nb++;
            tick();
            cB = CW'($urandom);
         end else begin
            tick();
         end
      end
      vB = 0;
      rB = 0;
      err = (outs.size() != nb - 1) ? 1 : 0;
      for (int k = 0; k < outs.size(); k++)
         if (outs[k] !== DW'(k + 1)) err = 1;
      if (err != 0) begin
         bad++;
         $display("FAIL skid0_order got_n=%0d exp_n=%0d", outs.size(), nb - 1);
      end
      total++;
   endtask

   task automatic test_bubble_sat();
      doReset();
      rA = 1;
      rB = 1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL bubble c%0d got=%h exp=%h", i, obsA(), expA());
         end
         total++;
         tick();
      end
      if (bubA !== 4'd15 || bubB !== 4'd15) begin
         bad++;
         $display("FAIL bubble_sat got=%0d,%0d exp=15", bubA, bubB);
      end
      total++;
      rA = 0;
      rB = 0;
   endtask

   task automatic test_random();
      logic accA, accB;
      for (int i = 0; i < 400; i++) begin
         rA = ($urandom_range(0, 3) != 0);
         rB = ($urandom_range(0, 3) != 0);
         fA = ($urandom_range(0, 15) == 0);
         fB = ($urandom_range(0, 15) == 0);
         #1;
         if (obsA() !== expA()) begin
            bad++;
            $display("FAIL rand_a c%0d got=%h exp=%h", i, obsA(), expA());
         end
         total++;
         if (obsB() !== expB()) begin
            bad++;
            $display("FAIL rand_b c%0d got=%h exp=%h", i, obsB(), expB());
         end
         total++;
         accA = fA || !vA || (qA.size() < 2);
         accB = fB || !vB || rB || (qB.size() == 0);
         tick();
         if (accA) begin
            vA = ($urandom_range(0, 2) != 0);
            {cA, dA} = rndBeat();
         end
         if (accB) begin
            vB = ($urandom_range(0, 2) != 0);
            {cB, dB} = rndBeat();
         end
      end
      idleInputs();
   endtask

   initial begin
      idleInputs();
      rstN = 1'b0;
      resetModels();
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      test_reset();
      test_stream();
      test_stall_fill();
      test_flush();
      test_skid0();
      test_bubble_sat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
